// File: rtl/conv_fetch_ctrl.sv
// Fetch-job sequencer for the CONV read mux: issues framed address beats, tracks returned data.
// Optional error flag under CONV_FETCH_CTRL_ERR_EN.
module conv_fetch_ctrl #(
  parameter int AW      = 13,
  parameter int IFW     = 4,
  parameter int LW      = 10,
  parameter int MAX_OUT = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [AW-1:0]  cmd_base,
  input  logic [AW-1:0]  cmd_stride,
  input  logic [LW-1:0]  cmd_len,
  input  logic [IFW-1:0] cmd_info,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  output logic [IFW-1:0] info,
  output logic [AW-1:0]  m_addr,
  output logic           m_addr_first,
  output logic           m_addr_last,
  output logic           m_addr_valid,
  input  logic           m_addr_ready,
  input  logic           dat_valid,
  input  logic           dat_ready,
  output logic           busy,
  output logic           done
`ifdef CONV_FETCH_CTRL_ERR_EN
  ,
  output logic           err
`endif
);

  // state  | meaning
  // IDLE   | waiting for a descriptor, cmd_ready high
  // ISSUE  | emitting address beats, throttled by outstanding count
  // DRAIN  | all beats issued, waiting for the remaining data returns
  localparam int OW = $clog2(MAX_OUT + 1);
  localparam int CW = LW + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]    state;
  logic [AW-1:0] addr;
  logic [AW-1:0] stride;
  logic [LW-1:0] len;
  logic [CW-1:0] issue_cnt;
  logic [CW-1:0] ret_cnt;
  logic [OW-1:0] outstanding;
  logic          afire;
  logic          dfire;
  logic          dfire_eff;
  logic          ret_final;

  assign cmd_ready    = (state == S_IDLE);
  assign busy         = (state != S_IDLE);
  assign m_addr       = addr;
  assign m_addr_valid = (state == S_ISSUE) && (outstanding < OW'(MAX_OUT));
  assign m_addr_first = (state == S_ISSUE) && (issue_cnt == '0);
  assign m_addr_last  = (state == S_ISSUE) && (issue_cnt == {1'b0, len});

  assign afire     = m_addr_valid & m_addr_ready;
  assign dfire     = dat_valid & dat_ready;
  // returns with nothing outstanding are dropped so the counters never underflow
  assign dfire_eff = dfire && (outstanding != '0) && busy;
  assign ret_final = dfire_eff && (ret_cnt == {1'b0, len});

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      addr        <= '0;
      stride      <= '0;
      len         <= '0;
      info        <= '0;
      issue_cnt   <= '0;
      ret_cnt     <= '0;
      outstanding <= '0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            addr      <= cmd_base;
            stride    <= cmd_stride;
            len       <= cmd_len;
            info      <= cmd_info;
            issue_cnt <= '0;
            ret_cnt   <= '0;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (afire) begin
            addr      <= addr + stride;
            issue_cnt <= issue_cnt + CW'(1);
            if (m_addr_last) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
        end
        default: state <= S_IDLE;
      endcase

      if (dfire_eff) ret_cnt <= ret_cnt + CW'(1);

      // the final return always follows the last issue, so this overrides any ISSUE/DRAIN update
      if (ret_final) begin
        state <= S_IDLE;
        done  <= 1'b1;
      end

      case ({afire, dfire_eff})
        2'b10:   outstanding <= outstanding + OW'(1);
        2'b01:   outstanding <= outstanding - OW'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

`ifdef CONV_FETCH_CTRL_ERR_EN
  logic [10:0] hold_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err      <= 1'b0;
      hold_cnt <= '0;
    end else begin
      if (dfire && ((outstanding == '0) || (state == S_IDLE))) err <= 1'b1;
      // a descriptor stuck waiting more than 1024 busy cycles is flagged
      if (busy && cmd_valid) begin
        if (hold_cnt == 11'd1024) err <= 1'b1;
        else hold_cnt <= hold_cnt + 11'd1;
      end else begin
        hold_cnt <= '0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_conv_fetch_ctrl.sv
// Bench for conv_fetch_ctrl: job-level scoreboard, directed job table, corner sequences, random jobs.
module tb_conv_fetch_ctrl;
  localparam int AW = 13, IFW = 4, LW = 10, MO = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n;
  logic [AW-1:0]  cmd_base, cmd_stride, m_addr;
  logic [LW-1:0]  cmd_len;
  logic [IFW-1:0] cmd_info, info;
  logic cmd_valid, cmd_ready, m_addr_first, m_addr_last, m_addr_valid, m_addr_ready;
  logic dat_valid, dat_ready, busy, done;
`ifdef CONV_FETCH_CTRL_ERR_EN
  logic err;
`endif

  conv_fetch_ctrl #(.AW(AW), .IFW(IFW), .LW(LW), .MAX_OUT(MO)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_base(cmd_base), .cmd_stride(cmd_stride), .cmd_len(cmd_len), .cmd_info(cmd_info),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .info(info),
    .m_addr(m_addr), .m_addr_first(m_addr_first), .m_addr_last(m_addr_last),
    .m_addr_valid(m_addr_valid), .m_addr_ready(m_addr_ready),
    .dat_valid(dat_valid), .dat_ready(dat_ready), .busy(busy), .done(done)
`ifdef CONV_FETCH_CTRL_ERR_EN
    , .err(err)
`endif
  );

  int vectors = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // stimulus controls (written by main, read by responder)
  bit withhold = 0, force_dv = 0, spur = 0, rnd_ardy = 0, rnd_drdy = 0;
  int lat = 2;
  bit mon_en = 0;

  // reference model: one job, beats numbered 0..len, addresses base + k*stride mod 2^AW
  int due_q[$];
  int cyc = 0;
  bit act = 0;
  int j_base, j_stride, j_len, idx, ret, out_m;
  bit exp_done = 0, err_m = 0;
  int exp_info = 0, hold = 0;
  int cap_beats = 0, cap_done = 0, cap_first = 0, cap_last = 0;
  logic [1:0] cap_fl = 2'b00;

  always @(negedge clk) begin
    bit ev, af, df, dfe, nd, was_act;
    int ea, tmp;
    ev = act && (idx <= j_len) && (out_m < MO);
    ea = (j_base + idx * j_stride) % (1 << AW);
    if (mon_en) begin
      chk("busy", busy, act);
      chk("cmd_ready", cmd_ready, !act);
      chk("done", done, exp_done);
      chk("info", info, exp_info);
      chk("m_addr_valid", m_addr_valid, ev);
      if (ev) begin
        chk("m_addr", m_addr, ea);
        chk("first", m_addr_first, idx == 0);
        chk("last", m_addr_last, idx == j_len);
      end
`ifdef CONV_FETCH_CTRL_ERR_EN
      chk("err", err, err_m);
`endif
    end
    if (m_addr_valid === 1'b1 && m_addr_ready === 1'b1) begin
      cap_beats++;
      cap_last = m_addr;
      cap_fl = {m_addr_first, m_addr_last};
      if (m_addr_first === 1'b1) cap_first = m_addr;
    end
    if (done === 1'b1) cap_done++;

    if (rst_n !== 1'b1) begin
      act = 0; idx = 0; ret = 0; out_m = 0; exp_done = 0; exp_info = 0;
      err_m = 0; hold = 0; due_q.delete();
    end else begin
      was_act = act;
      nd = 0;
      af = ev && m_addr_ready;
      df = dat_valid && dat_ready;
      if (df && (!was_act || out_m == 0)) err_m = 1;
      if (was_act && cmd_valid) begin
        hold++;
        if (hold > 1024) err_m = 1;
      end else hold = 0;
      if (af) begin
        due_q.push_back(cyc + lat);
        idx++;
      end
      if (df && due_q.size() > 0) tmp = due_q.pop_front();
      dfe = df && out_m > 0;
      out_m = out_m + int'(af) - int'(dfe);
      if (dfe) begin
        ret++;
        if (ret == j_len + 1) begin act = 0; nd = 1; end
      end
      if (!was_act && cmd_valid) begin
        act = 1; j_base = cmd_base; j_stride = cmd_stride; j_len = cmd_len;
        exp_info = cmd_info; idx = 0; ret = 0;
      end
      exp_done = nd;
    end
    cyc++;
  end

  // data-return and address-ready responder
  initial begin
    dat_valid = 0; dat_ready = 0; m_addr_ready = 0;
    forever begin
      @(posedge clk); #2;
      if (withhold) dat_valid = 1'b0;
      else dat_valid = (due_q.size() > 0 && due_q[0] <= cyc) || force_dv ||
                       (spur && $urandom_range(0, 9) == 0);
      dat_ready    = rnd_drdy ? ($urandom_range(0, 3) != 0) : 1'b1;
      m_addr_ready = rnd_ardy ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic send_job(input int b, input int s, input int l, input int i);
    bit ok = 0;
    cmd_base = AW'(b); cmd_stride = AW'(s); cmd_len = LW'(l); cmd_info = IFW'(i);
    cmd_valid = 1'b1;
    for (int k = 0; k < 3000 && !ok; k++) begin
      @(negedge clk);
      if (cmd_ready === 1'b1) ok = 1;
    end
    if (!ok) chk("accept_timeout", 0, 1);
    @(posedge clk); #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    bit ok = 0;
    for (int k = 0; k < budget && !ok; k++) begin
      @(negedge clk);
      if (busy === 1'b0) ok = 1;
    end
    if (!ok) chk("idle_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  typedef struct {
    int base, stride, len, inf;
    int exp_first, exp_last, exp_beats;
  } vec_t;
  vec_t tbl[6];

  initial begin
    int b0, d0;
    bit got;
    tbl[0] = '{'h010,  1,       3,    'h3, 'h010,  'h013,  4};
    tbl[1] = '{'h1FFE, 3,       2,    'h5, 'h1FFE, 'h0004, 3};
    tbl[2] = '{'h100,  'h10,    0,    'h8, 'h100,  'h100,  1};
    tbl[3] = '{'h0FF0, 'h1000,  5,    'h9, 'h0FF0, 'h1FF0, 6};
    tbl[4] = '{'h0000, 1,       1023, 'h7, 'h0000, 'h03FF, 1024};
    tbl[5] = '{'h1234, 'h1FFF,  4,    'hC, 'h1234, 'h1230, 5};

    rst_n = 0; cmd_valid = 0; cmd_base = 0; cmd_stride = 0; cmd_len = 0; cmd_info = 0;
    tick(3);
    rst_n = 1; mon_en = 1;
    @(negedge clk);
    chk("rst_info", info, 0);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_valid", m_addr_valid, 0);
    chk("rst_first_last", {m_addr_first, m_addr_last}, 0);
    chk("rst_busy_done", {busy, done}, 0);
    @(posedge clk); #1;

    // directed job table, fixed 2-cycle return latency
    lat = 2;
    for (int t = 0; t < 6; t++) begin
      b0 = cap_beats; d0 = cap_done;
      send_job(tbl[t].base, tbl[t].stride, tbl[t].len, tbl[t].inf);
      wait_idle(10000);
      tick(2);
      chk($sformatf("tbl%0d_beats", t), cap_beats - b0, tbl[t].exp_beats);
      chk($sformatf("tbl%0d_first", t), cap_first, tbl[t].exp_first);
      chk($sformatf("tbl%0d_last", t), cap_last, tbl[t].exp_last);
      chk($sformatf("tbl%0d_done", t), cap_done - d0, 1);
    end

    // backpressure: data withheld, issue stops at MAX_OUT beats
    b0 = cap_beats; withhold = 1;
    send_job('h200, 2, 7, 'h2);
    tick(20);
    chk("bp_afires", cap_beats - b0, MO);
    chk("bp_valid_low", m_addr_valid, 0);
    withhold = 0;
    wait_idle(1000);
    chk("bp_total", cap_beats - b0, 8);

    // back-to-back: single-beat A then queued B
    send_job('h040, 1, 0, 'h8);
    cmd_base = 'h080; cmd_stride = 1; cmd_len = 1; cmd_info = 'h1; cmd_valid = 1;
    got = 0;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      if (done === 1'b1) got = 1;
    end
    chk("b2b_done_seen", got, 1);
    chk("b2b_info_at_done", info, 'h8);
    chk("b2b_a_first_last", cap_fl, 2'b11);
    @(negedge clk);
    chk("b2b_info_b", info, 'h1);
    chk("b2b_busy_b", busy, 1);
    @(posedge clk); #1 cmd_valid = 0;
    wait_idle(200);

    // reset in the middle of a job
    b0 = cap_beats; d0 = cap_done; withhold = 1;
    send_job('h500, 4, 5, 'hA);
    tick(10);
    chk("rmid_afires", cap_beats - b0, 2);
    rst_n = 0;
    tick(1);
    rst_n = 1; withhold = 0;
    @(negedge clk);
    chk("rmid_outputs", {info, m_addr, m_addr_first, m_addr_last, m_addr_valid, busy, done}, 0);
    chk("rmid_no_done", cap_done - d0, 0);
    @(posedge clk); #1;
    d0 = cap_done;
    send_job('h300, 1, 2, 'h4);
    wait_idle(200);
    chk("rmid_next_first", cap_first, 'h300);
    chk("rmid_next_done", cap_done - d0, 1);

    // randomized jobs against the scoreboard
    rnd_ardy = 1; rnd_drdy = 1; spur = 1;
    for (int j = 0; j < 40; j++) begin
      lat = $urandom_range(1, 4);
      send_job($urandom_range(0, 8191), $urandom_range(0, 8191), $urandom_range(0, 15),
               $urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) wait_idle(2000);
    end
    wait_idle(2000);
    rnd_ardy = 0; rnd_drdy = 0; spur = 0; lat = 2;

`ifdef CONV_FETCH_CTRL_ERR_EN
    do_reset();
    @(negedge clk);
    chk("err_after_reset", err, 0);
    @(posedge clk); #1 force_dv = 1;
    tick(1);
    force_dv = 0;
    tick(2);
    chk("err_idle_dfire", err, 1);
    send_job('h020, 1, 3, 'h3);
    wait_idle(200);
    chk("err_sticky", err, 1);
    do_reset();
    @(negedge clk);
    chk("err_cleared", err, 0);
`endif

    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $fatal(1, "watchdog");
  end
endmodule
